roberto_scan: RTL

Parametrised N-channel ultrasonic scan controller, the successor to the fixed three-sensor measurement path in the roberto top level. It does the following for each channel enabled in a mask:
- fires the trigger;
- times the echo pulse;
- converts the pulse width to a 3-digit BCD distance in centimetres, with timeout detection;
- presents one result per channel on a valid/ready port toward the serial transmit stage.

It runs a single scan per `start` or scans continuously. It replaces the per-sensor medir/pronto sequencing in the UC.

---
 rtl/roberto_pkg.sv | 37 +++
 rtl/bcd_counter_sat3.sv | 32 +++
 rtl/roberto_scan.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/roberto_pkg.sv
// Shared constants, state codes and channel-selection helper for the roberto scan path.
package roberto_pkg;

  localparam int          CH_W         = 3;
  localparam logic [11:0] DIST_TIMEOUT = 12'hFFF;
  localparam logic [11:0] DIST_SAT     = 12'h999;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TRIG      = 4'd1,
    S_WAIT_ECHO = 4'd2,
    S_MEASURE   = 4'd3,
    S_EMIT      = 4'd4,
    S_GAP       = 4'd5,
    S_NEXT      = 4'd6,
    S_DONE      = 4'd7
  } state_t;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } ch_pick_t;

  // Lowest enabled channel whose index is >= from; found=0 when none remains.
  function automatic ch_pick_t pick_channel(input logic [7:0] mask, input logic [CH_W:0] from);
    ch_pick_t p;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        p.found = 1'b1;
        p.idx   = CH_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_counter_sat3.sv
// Three-digit BCD up-counter with synchronous clear, count enable and saturation at 999.
module bcd_counter_sat3
  import roberto_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [11:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable && (value != DIST_SAT)) begin
      if (value[3:0] == 4'd9) begin
        value[3:0] <= 4'd0;
        if (value[7:4] == 4'd9) begin
          value[7:4]  <= 4'd0;
          value[11:8] <= value[11:8] + 4'd1;
        end else begin
          value[7:4] <= value[7:4] + 4'd1;
        end
      end else begin
        value[3:0] <= value[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/roberto_scan.sv
// N-channel ultrasonic scan controller: trigger, echo timing, BCD distance and
// one valid/ready result per enabled channel.
module roberto_scan
  import roberto_pkg::*;
#(
  parameter int N_CH           = 3,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 3_000_000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            continuous,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CH_W-1:0] res_ch,
  output logic [11:0]     res_dist,
  output logic            res_timeout,
  output logic            busy,
  output logic            done,
  output logic [3:0]      db_estado
);

  localparam int TRW = $clog2(TRIG_CYCLES + 1);
  localparam int PSW = $clog2(CYCLES_PER_CM + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GPW = $clog2(GAP_CYCLES + 1);
  localparam logic [TRW-1:0] TRIG_LAST = TRW'(TRIG_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST   = PSW'(CYCLES_PER_CM - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [GPW-1:0] GAP_LAST  = GPW'(GAP_CYCLES - 1);

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [7:0]      mask_q;
  logic [TRW-1:0]  trig_cnt;
  logic [PSW-1:0]  presc;
  logic [TOW-1:0]  tcnt;
  logic [GPW-1:0]  gcnt;
  logic [N_CH-1:0] rise, fall;
  logic [7:0]      rise8, fall8, onehot8;
  logic            rise_sel, fall_sel, tout_hit, bcd_clear, bcd_en;
  logic [11:0]     bcd_val;
  ch_pick_t        start_pick, next_pick;

  // Two-flop synchronizer plus one delay flop for edge detection, per channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_echo
    logic s1, s2, s3;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        s3 <= 1'b0;
      end else begin
        s1 <= echo[g];
        s2 <= s1;
        s3 <= s2;
      end
    end
    assign rise[g] = s2 & ~s3;
    assign fall[g] = ~s2 & s3;
  end

  assign rise8      = 8'(rise);
  assign fall8      = 8'(fall);
  assign onehot8    = 8'd1 << ch;
  assign rise_sel   = rise8[ch];
  assign fall_sel   = fall8[ch];
  assign tout_hit   = (tcnt == TO_LAST);
  assign start_pick = pick_channel(8'(ch_mask), '0);
  assign next_pick  = pick_channel(mask_q, {1'b0, ch} + 4'd1);
  assign db_estado  = state;

  // The rise-detect cycle counts as the first echo clock, so the prescaler restarts at 1.
  assign bcd_clear = (state == S_WAIT_ECHO) && !tout_hit && rise_sel;
  assign bcd_en    = (state == S_MEASURE) && !fall_sel && !tout_hit && (presc == PS_LAST);

  bcd_counter_sat3 u_bcd (
    .clock  (clock),
    .reset  (reset),
    .clear  (bcd_clear),
    .enable (bcd_en),
    .value  (bcd_val)
  );

  // Result port: a transfer happens on a clock edge where res_valid && res_ready;
  // res_ch/res_dist/res_timeout stay constant while res_valid is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ch          <= '0;
      mask_q      <= '0;
      trig_cnt    <= '0;
      presc       <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
      trigger     <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_dist    <= '0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done    <= 1'b0;
      trigger <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if ((state == S_IDLE && start) || (state == S_DONE && continuous)) begin
            mask_q   <= 8'(ch_mask);
            busy     <= 1'b1;
            trig_cnt <= '0;
            if (start_pick.found) begin
              ch    <= start_pick.idx;
              state <= S_TRIG;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (state == S_DONE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_TRIG: begin
          trigger <= onehot8[N_CH-1:0];
          if (trig_cnt == TRIG_LAST) begin
            state <= S_WAIT_ECHO;
            tcnt  <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end
        S_WAIT_ECHO: begin
          if (tout_hit) begin
            res_ch      <= ch;
            res_dist    <= DIST_TIMEOUT;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= S_EMIT;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (rise_sel) begin
              presc <= PSW'(1);
              state <= S_MEASURE;
            end
          end
        end
        S_MEASURE: begin
          if (fall_sel || tout_hit) begin
            res_ch      <= ch;
            res_dist    <= fall_sel ? bcd_val : DIST_TIMEOUT;
            res_timeout <= !fall_sel;
            res_valid   <= 1'b1;
            state       <= S_EMIT;
          end else begin
            tcnt  <= tcnt + 1'b1;
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            gcnt      <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) state <= S_NEXT;
          else                  gcnt  <= gcnt + 1'b1;
        end
        S_NEXT: begin
          trig_cnt <= '0;
          if (next_pick.found) begin
            ch    <= next_pick.idx;
            state <= S_TRIG;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
